// File: rtl/kmp_table_builder.sv
// KMP failure-table builder: walks the stored pattern through a registered
// RAM address and fills a signed table (T[0] = -1) read combinationally by the searcher.
module kmp_table_builder #(
    parameter int PAT_MAX = 16,
    parameter int CHAR_W  = 8,
    parameter int IDX_W   = $clog2(PAT_MAX) + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [IDX_W-1:0]        pat_len,
    output logic [IDX_W-2:0]        pat_addr,
    input  logic [CHAR_W-1:0]       pat_data,
    input  logic [IDX_W-2:0]        t_rd_addr,
    output logic signed [IDX_W-1:0] t_rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [3:0]              actual_state
);
    localparam int AW = $clog2(PAT_MAX);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_INIT    = 4'd1,
        S_RD_POS  = 4'd2,
        S_LAT_POS = 4'd3,
        S_CMP1    = 4'd4,
        S_FAIL    = 4'd5,
        S_RD_CND  = 4'd6,
        S_CMP2    = 4'd7,
        S_ADV     = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         pos_q, pos_d;
    logic signed [IDX_W-1:0]  cnd_q, cnd_d;
    logic [CHAR_W-1:0]        ppos_q, ppos_d;
    logic [IDX_W-1:0]         len_q, len_d;
    logic [IDX_W-2:0]         pat_addr_q, pat_addr_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic signed [IDX_W-1:0]  tab_q [PAT_MAX];
    logic signed [IDX_W-1:0]  tab_d [PAT_MAX];

    logic signed [IDX_W-1:0]  t_cnd;
    logic [IDX_W-1:0]         pos_next;
    logic                     match;
    logic                     len_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pos_q      <= '0;
            cnd_q      <= '0;
            ppos_q     <= '0;
            len_q      <= '0;
            pat_addr_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < PAT_MAX; i++) tab_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            cnd_q      <= cnd_d;
            ppos_q     <= ppos_d;
            len_q      <= len_d;
            pat_addr_q <= pat_addr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            for (int i = 0; i < PAT_MAX; i++) tab_q[i] <= tab_d[i];
        end
    end

    // cnd is non-negative whenever it indexes the table or drives the address.
    assign t_cnd    = tab_q[cnd_q[AW-1:0]];
    assign pos_next = pos_q + IDX_W'(1);
    assign match    = (ppos_q == pat_data);
    assign len_bad  = (len_q == '0) || (len_q > IDX_W'(PAT_MAX));

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        cnd_d      = cnd_q;
        ppos_d     = ppos_q;
        len_d      = len_q;
        pat_addr_d = pat_addr_q;
        err_d      = err_q;
        done_d     = (state_q == S_DONE);
        for (int i = 0; i < PAT_MAX; i++) tab_d[i] = tab_q[i];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = pat_len;
                    err_d   = 1'b0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (len_bad) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tab_d[0] = '1;
                    pos_d    = IDX_W'(1);
                    cnd_d    = '0;
                    state_d  = (len_q == IDX_W'(1)) ? S_DONE : S_RD_POS;
                end
            end
            S_RD_POS: begin
                pat_addr_d = pos_q[IDX_W-2:0];
                state_d    = S_LAT_POS;
            end
            S_LAT_POS: begin
                ppos_d     = pat_data;
                pat_addr_d = cnd_q[IDX_W-2:0];
                state_d    = S_CMP1;
            end
            S_CMP1: begin
                tab_d[pos_q[AW-1:0]] = match ? t_cnd : cnd_q;
                state_d              = match ? S_ADV : S_FAIL;
            end
            S_FAIL: begin
                cnd_d   = t_cnd;
                state_d = t_cnd[IDX_W-1] ? S_ADV : S_RD_CND;
            end
            S_RD_CND: begin
                pat_addr_d = cnd_q[IDX_W-2:0];
                state_d    = S_CMP2;
            end
            S_CMP2: begin
                state_d = match ? S_ADV : S_FAIL;
            end
            S_ADV: begin
                pos_d   = pos_next;
                cnd_d   = cnd_q + IDX_W'(1);
                state_d = (pos_next == len_q) ? S_DONE : S_RD_POS;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        t_rd_data = '0;
        if (t_rd_addr < (IDX_W-1)'(PAT_MAX)) t_rd_data = tab_q[t_rd_addr[AW-1:0]];
    end

    assign pat_addr     = pat_addr_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign err          = err_q;
    assign actual_state = state_q;
endmodule

// File: tb/tb_kmp_table_builder.sv
// Directed bench for kmp_table_builder: hand-computed KMP tables, error
// lengths, single-length latency, ignored start and reset mid-build.
module tb_kmp_table_builder;
    localparam int PAT_MAX = 16;
    localparam int CHAR_W  = 8;
    localparam int IDX_W   = $clog2(PAT_MAX) + 2;

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic [IDX_W-1:0]        pat_len;
    logic [IDX_W-2:0]        pat_addr;
    logic [CHAR_W-1:0]       pat_data;
    logic [IDX_W-2:0]        t_rd_addr;
    logic signed [IDX_W-1:0] t_rd_data;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic [3:0]              actual_state;

    logic [CHAR_W-1:0] mem [32];
    int model [16];
    int n_chk = 0;
    int n_bad = 0;
    int done_cnt = 0;

    kmp_table_builder #(.PAT_MAX(PAT_MAX), .CHAR_W(CHAR_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .start(start), .pat_len(pat_len),
        .pat_addr(pat_addr), .pat_data(pat_data),
        .t_rd_addr(t_rd_addr), .t_rd_data(t_rd_data),
        .busy(busy), .done(done), .err(err), .actual_state(actual_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern RAM: data for the address registered in the previous state
    assign pat_data = mem[pat_addr];

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic load_pat(input string s);
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) mem[i] = s[i];
    endtask

    task automatic start_build(input int len);
        @(negedge clk);
        start   = 1'b1;
        pat_len = IDX_W'(len);
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Returns edges after start_build returns until done is seen (0 = timeout)
    task automatic wait_done(output int edges, output int err_seen);
        edges    = 0;
        err_seen = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges    = i;
                err_seen = int'(err);
                break;
            end
        end
        if (edges == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 16; i++) begin
            t_rd_addr = 5'(i);
            #1;
            chk($sformatf("%s_T%0d", tag, i), int'(t_rd_data), model[i]);
        end
    endtask

    task automatic set_model(input int len, input int v [16]);
        for (int i = 0; i < len; i++) model[i] = v[i];
    endtask

    // Full legal build with a single done pulse and clean err
    task automatic build_and_check(input string tag, input string s, input int v [16]);
        int edges, e, c0;
        load_pat(s);
        c0 = done_cnt;
        start_build(s.len());
        wait_done(edges, e);
        chk({tag, "_err"}, e, 0);
        repeat (3) @(negedge clk);
        chk({tag, "_pulses"}, done_cnt - c0, 1);
        set_model(s.len(), v);
        check_table(tag);
    endtask

    initial begin
        int v [16];
        int edges, e, c0, found;
        rst = 1'b1; start = 1'b0; pat_len = '0; t_rd_addr = '0;
        for (int i = 0; i < 16; i++) model[i] = 0;
        load_pat("");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_state", int'(actual_state), 0);
        check_table("rst");

        v = '{-1, 0, 0, 0, -1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        build_and_check("abcdabd", "ABCDABD", v);

        v = '{-1, 0, -1, 1, -1, 0, -1, 3, 2, 0, 0, 0, 0, 0, 0, 0};
        build_and_check("abacababc", "ABACABABC", v);

        v = '{-1, -1, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        build_and_check("aaaa", "AAAA", v);

        // Length 1: start sampled at edge k, done visible after edge k+2
        load_pat("Z");
        start_build(1);
        wait_done(edges, e);
        chk("len1_edges", edges + 1, 3);
        chk("len1_err", e, 0);
        model[0] = -1;
        check_table("len1");

        // Illegal lengths leave the table alone and hold err
        c0 = done_cnt;
        start_build(0);
        wait_done(edges, e);
        chk("len0_err", e, 1);
        chk("len0_edges", edges + 1, 3);
        repeat (4) @(negedge clk);
        chk("len0_err_hold", int'(err), 1);
        chk("len0_pulses", done_cnt - c0, 1);
        check_table("len0");

        start_build(17);
        wait_done(edges, e);
        chk("len17_err", e, 1);
        check_table("len17");

        load_pat("Q");
        start_build(1);
        chk("err_clear_on_start", int'(err), 0);
        wait_done(edges, e);
        chk("err_clear_done", e, 0);

        // Mid-build start is ignored; reset during FAIL aborts and clears
        load_pat("ABCDABD");
        start_build(7);
        @(negedge clk);
        start = 1'b1; pat_len = IDX_W'(4);
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (actual_state == 4'd5) begin
                found = 1;
                break;
            end
        end
        chk("reach_fail", found, 1);
        rst = 1'b1;
        #1;
        chk("abort_state", int'(actual_state), 0);
        chk("abort_busy", int'(busy), 0);
        for (int i = 0; i < 16; i++) model[i] = 0;
        check_table("abort");
        @(negedge clk);
        start = 1'b1; pat_len = IDX_W'(7);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("rst_beats_start", int'(actual_state), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_state", int'(actual_state), 0);

        // Rerun with a stray start mid-build
        c0 = done_cnt;
        start_build(7);
        repeat (2) @(negedge clk);
        start = 1'b1; pat_len = IDX_W'(4);
        @(negedge clk);
        start = 1'b0;
        wait_done(edges, e);
        chk("rerun_err", e, 0);
        repeat (3) @(negedge clk);
        chk("rerun_pulses", done_cnt - c0, 1);
        v = '{-1, 0, 0, 0, -1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        set_model(7, v);
        check_table("rerun");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
